// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Word-aligned byte address: bits 30:31 (the two LSBs) forced to zero.
    localparam logic [0:31] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic valid;
        logic owner;
        logic write;
        logic err;
    } rsp_tag_t;

endpackage

// File: rtl/bram_rr_arbiter.sv
// Two-input round-robin arbiter; the last winner may hold the port for up to
// C_BURST_MAX consecutive grants while the other requester is waiting.
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned C_BURST_MAX = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    localparam logic [3:0] BURST_MAX = 4'(C_BURST_MAX);

    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       both;
    logic       hold;
    logic       win;

    assign both = req_i[0] & req_i[1];
    // A zero count (only after reset) never holds, so M0 wins the first contest.
    assign hold = (cnt_q != 4'd0) && (cnt_q < BURST_MAX);

    always_comb begin
        gnt_o = 2'b00;
        win   = last_q;
        if (rst_ni) begin
            if (both) begin
                win        = hold ? last_q : ~last_q;
                gnt_o[win] = 1'b1;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        cnt_d  = 4'd1;
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
            if ((gnt_o[1] == last_q) && both) begin
                cnt_d = (cnt_q < BURST_MAX) ? cnt_q + 4'd1 : cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_M1;
            cnt_q  <= 4'd0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the SD-copy engine (M0) and the debug/loader
// path (M1); accesses issue on the accepting edge, responses return one cycle later.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned C_MEMSIZE     = 'h2000,
    parameter int unsigned C_PORT_DWIDTH = 32,
    parameter int unsigned C_PORT_AWIDTH = 32,
    parameter int unsigned C_NUM_WE      = 4,
    parameter int unsigned C_BURST_MAX   = 4
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst_N,

    input  logic                     M0_Valid,
    output logic                     M0_Ready,
    input  logic                     M0_Write,
    input  logic [0:C_PORT_AWIDTH-1] M0_Addr,
    input  logic [0:C_PORT_DWIDTH-1] M0_WData,
    input  logic [0:C_NUM_WE-1]      M0_BE,
    output logic                     M0_Rsp_Valid,
    output logic                     M0_Rsp_Err,
    output logic [0:C_PORT_DWIDTH-1] M0_Rsp_RData,

    input  logic                     M1_Valid,
    output logic                     M1_Ready,
    input  logic                     M1_Write,
    input  logic [0:C_PORT_AWIDTH-1] M1_Addr,
    input  logic [0:C_PORT_DWIDTH-1] M1_WData,
    input  logic [0:C_NUM_WE-1]      M1_BE,
    output logic                     M1_Rsp_Valid,
    output logic                     M1_Rsp_Err,
    output logic [0:C_PORT_DWIDTH-1] M1_Rsp_RData,

    output logic                     BRAM_EN,
    output logic [0:C_NUM_WE-1]      BRAM_WEN,
    output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

    localparam logic [0:C_PORT_AWIDTH-1] MEM_LIMIT = C_PORT_AWIDTH'(C_MEMSIZE);

    logic [1:0]               gnt;
    logic                     granted;
    logic                     sel;
    logic                     sel_write;
    logic [0:C_PORT_AWIDTH-1] sel_addr;
    logic [0:C_PORT_DWIDTH-1] sel_wdata;
    logic [0:C_NUM_WE-1]      sel_be;
    logic                     sel_err;
    logic                     access;
    logic                     rd_ok;
    rsp_tag_t                 tag_q, tag_d;

    bram_rr_arbiter #(
        .C_BURST_MAX(C_BURST_MAX)
    ) u_arb (
        .clk_i (BRAM_Clk),
        .rst_ni(BRAM_Rst_N),
        .req_i ({M1_Valid, M0_Valid}),
        .gnt_o (gnt)
    );

    assign M0_Ready = gnt[0] & M0_Valid;
    assign M1_Ready = gnt[1] & M1_Valid;

    assign granted   = |gnt;
    assign sel       = gnt[1];
    assign sel_write = sel ? M1_Write : M0_Write;
    assign sel_addr  = sel ? M1_Addr  : M0_Addr;
    assign sel_wdata = sel ? M1_WData : M0_WData;
    assign sel_be    = sel ? M1_BE    : M0_BE;
    assign sel_err   = sel_addr >= MEM_LIMIT;

    // Out-of-range requests are still accepted but never touch the BRAM.
    assign access    = granted & ~sel_err;
    assign BRAM_EN   = access;
    assign BRAM_WEN  = (access && sel_write) ? sel_be : '0;
    assign BRAM_Addr = access ? (sel_addr & WORD_ALIGN_MASK) : '0;
    assign BRAM_Dout = access ? sel_wdata : '0;

    assign tag_d = '{valid: granted, owner: sel, write: sel_write, err: sel_err};

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign rd_ok = tag_q.valid & ~tag_q.write & ~tag_q.err;

    assign M0_Rsp_Valid = tag_q.valid & (tag_q.owner == REQ_M0);
    assign M1_Rsp_Valid = tag_q.valid & (tag_q.owner == REQ_M1);
    assign M0_Rsp_Err   = M0_Rsp_Valid & tag_q.err;
    assign M1_Rsp_Err   = M1_Rsp_Valid & tag_q.err;
    assign M0_Rsp_RData = (rd_ok && (tag_q.owner == REQ_M0)) ? BRAM_Din : '0;
    assign M1_Rsp_RData = (rd_ok && (tag_q.owner == REQ_M1)) ? BRAM_Din : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed plus randomized bench for bram_port_arbiter with a word-level
// memory/arbitration reference model and a simple synchronous BRAM model.
module tb_bram_port_arbiter;

    localparam int BURST = 4;
    localparam int MEMSIZE = 'h2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        M0_Valid = 1'b0, M0_Write = 1'b0;
    logic [0:31] M0_Addr = '0, M0_WData = '0;
    logic [0:3]  M0_BE = '0;
    logic        M0_Ready, M0_Rsp_Valid, M0_Rsp_Err;
    logic [0:31] M0_Rsp_RData;

    logic        M1_Valid = 1'b0, M1_Write = 1'b0;
    logic [0:31] M1_Addr = '0, M1_WData = '0;
    logic [0:3]  M1_BE = '0;
    logic        M1_Ready, M1_Rsp_Valid, M1_Rsp_Err;
    logic [0:31] M1_Rsp_RData;

    logic        BRAM_EN;
    logic [0:3]  BRAM_WEN;
    logic [0:31] BRAM_Addr, BRAM_Dout;
    logic [0:31] bram_dout = '0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .C_MEMSIZE(MEMSIZE), .C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32),
        .C_NUM_WE(4), .C_BURST_MAX(BURST)
    ) dut (
        .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
        .M0_Valid(M0_Valid), .M0_Ready(M0_Ready), .M0_Write(M0_Write),
        .M0_Addr(M0_Addr), .M0_WData(M0_WData), .M0_BE(M0_BE),
        .M0_Rsp_Valid(M0_Rsp_Valid), .M0_Rsp_Err(M0_Rsp_Err), .M0_Rsp_RData(M0_Rsp_RData),
        .M1_Valid(M1_Valid), .M1_Ready(M1_Ready), .M1_Write(M1_Write),
        .M1_Addr(M1_Addr), .M1_WData(M1_WData), .M1_BE(M1_BE),
        .M1_Rsp_Valid(M1_Rsp_Valid), .M1_Rsp_Err(M1_Rsp_Err), .M1_Rsp_RData(M1_Rsp_RData),
        .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
        .BRAM_Dout(BRAM_Dout), .BRAM_Din(bram_dout)
    );

    // Synchronous BRAM: read-first, data one cycle after EN.
    logic [0:31] bram_mem [2048];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        logic [0:31] w;
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) bram_mem[i] = '0;
            mem_init = 1'b1;
        end
        if (BRAM_EN) begin
            w = bram_mem[BRAM_Addr[19:29]];
            bram_dout <= w;
            for (int b = 0; b < 4; b++)
                if (BRAM_WEN[b]) w[8*b +: 8] = BRAM_Dout[8*b +: 8];
            bram_mem[BRAM_Addr[19:29]] = w;
        end
    end

    // Reference model state.
    logic [0:31] ref_mem [2048];
    int          m_last;
    int          m_streak;
    bit          p_valid, p_owner, p_write, p_err;
    logic [0:31] p_rdata;

    int          checks = 0;
    int          errors = 0;

    logic        obs_rdy0;
    logic [0:3]  obs_wen;
    logic [0:31] obs_rdata0;
    logic        obs_err1;
    logic [0:31] obs_rdata1;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_streak = 0;
        p_valid  = 1'b0;
        p_owner  = 1'b0;
        p_write  = 1'b0;
        p_err    = 1'b0;
        p_rdata  = '0;
    endtask

    // Assert reset with whatever requests are currently driven; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m0_ready", 32'(M0_Ready), 32'd0);
        chk("rst_m1_ready", 32'(M1_Ready), 32'd0);
        chk("rst_m0_rsp_valid", 32'(M0_Rsp_Valid), 32'd0);
        chk("rst_m1_rsp_valid", 32'(M1_Rsp_Valid), 32'd0);
        chk("rst_m0_rsp_err", 32'(M0_Rsp_Err), 32'd0);
        chk("rst_m1_rsp_err", 32'(M1_Rsp_Err), 32'd0);
        chk("rst_m0_rdata", M0_Rsp_RData, 32'd0);
        chk("rst_m1_rdata", M1_Rsp_RData, 32'd0);
        chk("rst_bram_en", 32'(BRAM_EN), 32'd0);
        chk("rst_bram_wen", 32'(BRAM_WEN), 32'd0);
        chk("rst_bram_addr", BRAM_Addr, 32'd0);
        chk("rst_bram_dout", BRAM_Dout, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive both requesters, check every output against the model, advance.
    task automatic cycle(input bit v0, input bit w0, input logic [0:31] a0, input logic [0:31] d0,
                         input logic [0:3] be0, input bit v1, input bit w1, input logic [0:31] a1,
                         input logic [0:31] d1, input logic [0:3] be1);
        int          win;
        bit          wr, err, en;
        logic [0:31] a, d, word;
        logic [0:3]  be;
        M0_Valid = v0; M0_Write = w0; M0_Addr = a0; M0_WData = d0; M0_BE = be0;
        M1_Valid = v1; M1_Write = w1; M1_Addr = a1; M1_WData = d1; M1_BE = be1;
        #4;
        if (v0 && v1) win = (m_streak > 0 && m_streak < BURST) ? m_last : 1 - m_last;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
        else          win = -1;
        wr  = (win == 1) ? w1 : w0;
        a   = (win == 1) ? a1 : a0;
        d   = (win == 1) ? d1 : d0;
        be  = (win == 1) ? be1 : be0;
        err = (win >= 0) && (a >= 32'(MEMSIZE));
        en  = (win >= 0) && !err;

        obs_rdy0   = M0_Ready;
        obs_wen    = BRAM_WEN;
        obs_rdata0 = M0_Rsp_RData;
        obs_err1   = M1_Rsp_Err;
        obs_rdata1 = M1_Rsp_RData;

        chk("m0_ready", 32'(M0_Ready), 32'(win == 0));
        chk("m1_ready", 32'(M1_Ready), 32'(win == 1));
        chk("m0_rsp_valid", 32'(M0_Rsp_Valid), 32'(p_valid && !p_owner));
        chk("m1_rsp_valid", 32'(M1_Rsp_Valid), 32'(p_valid && p_owner));
        chk("m0_rsp_err", 32'(M0_Rsp_Err), 32'(p_valid && !p_owner && p_err));
        chk("m1_rsp_err", 32'(M1_Rsp_Err), 32'(p_valid && p_owner && p_err));
        chk("m0_rsp_rdata", M0_Rsp_RData, (p_valid && !p_owner) ? p_rdata : 32'd0);
        chk("m1_rsp_rdata", M1_Rsp_RData, (p_valid && p_owner) ? p_rdata : 32'd0);
        chk("bram_en", 32'(BRAM_EN), 32'(en));
        chk("bram_wen", 32'(BRAM_WEN), 32'((en && wr) ? be : 4'b0000));
        chk("bram_addr", BRAM_Addr, en ? (a & 32'hFFFF_FFFC) : 32'd0);
        chk("bram_dout", BRAM_Dout, en ? d : 32'd0);

        p_valid = (win >= 0);
        p_owner = (win == 1);
        p_write = wr;
        p_err   = err;
        p_rdata = (en && !wr) ? ref_mem[a[19:29]] : 32'd0;
        if (en && wr) begin
            word = ref_mem[a[19:29]];
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = d[8*b +: 8];
            ref_mem[a[19:29]] = word;
        end
        if (win >= 0) begin
            if (win == m_last && v0 && v1) m_streak = (m_streak < BURST) ? m_streak + 1 : m_streak;
            else m_streak = 1;
            m_last = win;
        end else begin
            m_streak = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic m0(input bit w, input logic [0:31] a, input logic [0:31] d, input logic [0:3] be);
        cycle(1'b1, w, a, d, be, 1'b0, 1'b1, $urandom, $urandom, 4'hF);
    endtask

    task automatic m1(input bit w, input logic [0:31] a, input logic [0:31] d, input logic [0:3] be);
        cycle(1'b0, 1'b1, $urandom, $urandom, 4'hF, 1'b1, w, a, d, be);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, $urandom, $urandom, 4'hF, 1'b0, 1'b1, $urandom, $urandom, 4'hF);
    endtask

    function automatic logic [0:31] rnd_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_2000;
        return 32'($urandom_range(0, 32'h1FFF));
    endfunction

    initial begin
        logic [11:0] seq;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Full-word write then readback on M0.
        m0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        chk("wr_wen", 32'(obs_wen), 32'h0000_000F);
        m0(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        chk("rd_wen", 32'(obs_wen), 32'd0);
        idle();
        chk("rd_deadbeef", obs_rdata0, 32'hDEAD_BEEF);

        // Single-byte merge into an existing word.
        m0(1'b1, 32'h0000_0004, 32'h1122_3344, 4'b1111);
        m0(1'b1, 32'h0000_0006, 32'h00AA_0000, 4'b0100);
        m0(1'b0, 32'h0000_0005, 32'h0, 4'b0000);
        idle();
        chk("byte_merge", obs_rdata0, 32'h11AA_3344);

        // Out-of-range reads on M1: no access, error response with zero data.
        m1(1'b0, 32'h0000_2000, 32'h0, 4'b0000);
        m1(1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000);
        chk("oor_err_a", 32'(obs_err1), 32'd1);
        idle();
        chk("oor_err_b", 32'(obs_err1), 32'd1);
        chk("oor_rdata", obs_rdata1, 32'd0);

        // Continuous contention from reset: bursts of BURST grants alternate.
        do_reset();
        seq = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 32'($urandom_range(0, 32'h1FFF)), $urandom, 4'h0,
                  1'b1, 1'b0, 32'($urandom_range(0, 32'h1FFF)), $urandom, 4'h0);
            seq = {seq[10:0], obs_rdy0};
        end
        chk("grant_order", 32'(seq), 32'(12'b1111_0000_1111));
        idle();

        // M0 alone is never forced to yield.
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            m0($urandom_range(0, 1) == 1, rnd_addr(), $urandom, 4'($urandom_range(0, 15)));
            seq = {seq[10:0], obs_rdy0};
        end
        chk("m0_alone_ready", 32'(seq[9:0]), 32'h3FF);
        idle();

        // Reset while a read response is in flight: response is dropped.
        m0(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        M1_Valid = 1'b1;
        do_reset();
        cycle(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
        chk("post_reset_m0_first", 32'(obs_rdy0), 32'd1);
        idle();

        // Randomized traffic with frequent contention and idle gaps.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one 32-bit port of the processor BRAM block between two local-bus requesters: M0, the SD-card SPI block-copy engine, and M1, the debug/loader path.
- Performs round-robin arbitration with a bounded burst hold, checks addresses against the memory size, and drives the BRAM port signals.
- Returns a response to the granted requester a fixed number of cycles after acceptance.

Parameters:
C_MEMSIZE, 'h2000, BRAM size in bytes (power of two); byte addresses >= C_MEMSIZE are errors
C_PORT_DWIDTH, 32, data width (fixed 32; bit 0 = MSB)
C_PORT_AWIDTH, 32, address width
C_NUM_WE, 4, byte write enables (WE[0] = bits 0:7)
C_BURST_MAX, 4, max consecutive grants to one requester while the other waits (1..15)

Ports:
BRAM_Clk  in  1  clock for arbiter and BRAM port
BRAM_Rst_N  in  1  asynchronous active-low reset
Mx_Valid  in  1  request valid (x = 0, 1; M0 has priority after reset)
Mx_Ready  out  1  request accepted this cycle
Mx_Write  in  1  1 = write, 0 = read
Mx_Addr  in  [0:31]  byte address; bits 30:31 ignored (word aligned)
Mx_WData  in  [0:31]  write data
Mx_BE  in  [0:3]  byte enables for writes
Mx_Rsp_Valid  out  1  one-cycle response strobe
Mx_Rsp_Err  out  1  address out of range (valid with Rsp_Valid)
Mx_Rsp_RData  out  [0:31]  read data (valid with Rsp_Valid on reads; 0 on writes and errors)
BRAM_EN  out  1  port enable
BRAM_WEN  out  [0:3]  byte write enables
BRAM_Addr  out  [0:31]  word-aligned byte address (bits 30:31 = 0)
BRAM_Dout  out  [0:31]  write data to BRAM
BRAM_Din  in  [0:31]  read data from BRAM, one cycle after EN

Behaviour:
- Reset (BRAM_Rst_N low, asynchronous): all outputs 0, last-grant = M1 (so M0 wins first), burst counter 0, response pipeline flushed. An in-flight response is dropped, not delivered.
- Arbitration (combinational per cycle, one grant max):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that was not last granted wins, unless the last-granted requester still has burst count < C_BURST_MAX. In that case it keeps the grant.
  - Mx_Ready = grant & Mx_Valid. Ready never asserts without Valid.
- Burst counter (4 bit):
  - Increments when the same requester is granted on consecutive cycles while the other is valid.
  - Resets to 1 on a grant switch or an idle cycle.
  - Saturates at C_BURST_MAX, which forces a switch if the other requester is valid.
- Issue (same cycle as accept):
  - In-range request: BRAM_EN = 1, BRAM_WEN = Write ? BE : 0, Addr/Dout driven from the granted requester.
  - Out-of-range request: BRAM_EN = 0, WEN = 0 (no access).
  - Outputs are combinational from the grant mux, so BRAM sees the access on the accepting edge.
- Response (exactly 1 cycle after accept): registered tag {valid, owner, write, err} selects the target.
  - Mx_Rsp_Valid pulses for one cycle.
  - Rsp_RData = BRAM_Din for in-range reads; otherwise 0.
  - Err = 1 for out-of-range, with no data.
  - Writes also get a Rsp_Valid acknowledgement.
- Throughput: one access per cycle total. Back-to-back accepts give back-to-back responses. No stalls; requesters must always accept responses.
- Simultaneous accept and response for the same requester is legal (pipelined).
- Valid dropped without Ready: no state change. Addr/data may change freely while not accepted.
- Range check: err = (Addr >= C_MEMSIZE), unsigned compare on the full 32 bits.

Decomposition:
- Package bram_arb_pkg:
  - Requester-ID constants (M0 = 0, M1 = 1).
  - Response-tag record type {valid, owner, write, err}.
  - Word-align mask constant.
- One sub-module, bram_rr_arbiter: two-input round-robin arbiter with burst counter, producing grant and last-grant. The top level holds the mux, range check and response pipeline.

Test Plan:
- Reset then M0 writes 'hDEADBEEF to 'h0010 with BE = 1111, then reads 'h0010 -> write ack next cycle; read Rsp_RData = 'hDEADBEEF, Err = 0; BRAM_WEN = 1111 on write and 0000 on read.
- Both valid continuously, C_BURST_MAX = 4, after reset -> grant order M0 M0 M0 M0 M1 M1 M1 M1 M0...; each Rsp_Valid appears exactly 1 cycle after its Ready.
- M1 reads 'h2000 and 'hFFFFFFFC -> BRAM_EN stays 0; M1_Rsp_Valid with Err = 1 and RData = 0 one cycle later.
- Byte write BE = 0100 of 'h00AA0000 to 'h0004 over prior 'h11223344 -> readback 'h11AA3344.
- Assert BRAM_Rst_N low in the cycle after an accepted read -> no Rsp_Valid, all outputs 0 immediately; after release M0 is granted first.
- M0 Valid alone every cycle for 10 cycles -> Ready every cycle (no forced yield without competition), 10 consecutive responses.
